// File: rtl/fazyrv_wb_arb_pkg.sv
// rtl/fazyrv_wb_arb_pkg.sv - grant FSM states and grant encodings shared by the imem/dmem Wishbone arbiter
package fazyrv_wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } arb_state_t;

  localparam logic [1:0] GNT_IMEM = 2'b01;
  localparam logic [1:0] GNT_DMEM = 2'b10;

  function automatic logic [1:0] state_to_gnt(input arb_state_t s);
    case (s)
      GNT_I:   return GNT_IMEM;
      GNT_D:   return GNT_DMEM;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/fazyrv_wb_tmo.sv
// rtl/fazyrv_wb_tmo.sv - grant watchdog, used only when FAZYRV_WB_ARB_TMO_EN is defined
// Counts ackless grant cycles; expire_o flags the TIMEOUT-th one unless the slave acks it.
module fazyrv_wb_tmo #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic active_i,
  input  logic ack_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Idle cycles hold the count at zero, so every new grant starts fresh.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (!active_i) begin
      r_cnt <= '0;
    end else if (!ack_i) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expire_o = active_i && !ack_i && (r_cnt == LAST);

endmodule

// File: rtl/fazyrv_wb_arb.sv
// rtl/fazyrv_wb_arb.sv - shares one Wishbone slave between imem and dmem masters (RR or DMEM priority)
// Optional grant watchdog enabled by FAZYRV_WB_ARB_TMO_EN.
module fazyrv_wb_arb
  import fazyrv_wb_arb_pkg::*;
#(
  parameter string PRIO    = "RR",
  parameter int    TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        imem_stb_i,
  input  logic        imem_cyc_i,
  input  logic [31:0] imem_adr_i,
  output logic [31:0] imem_dat_o,
  output logic        imem_ack_o,
  input  logic        dmem_cyc_i,
  input  logic        dmem_stb_i,
  input  logic        dmem_we_i,
  input  logic [3:0]  dmem_be_i,
  input  logic [31:0] dmem_adr_i,
  input  logic [31:0] dmem_dat_i,
  output logic [31:0] dmem_dat_o,
  output logic        dmem_ack_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_be_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic [1:0]  gnt_o,
  output logic        tmo_o
);

  localparam bit DMEM_PRIO = (PRIO == "DMEM");

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("fazyrv_wb_arb: TIMEOUT must be >= 2");
  end

  arb_state_t r_state, w_next;
  logic       r_last_dmem, w_last_dmem_next;
  logic       w_req_i, w_req_d, w_cyc_g, w_ack_g, w_tmo;

  assign w_req_i = imem_cyc_i & imem_stb_i;
  assign w_req_d = dmem_cyc_i & dmem_stb_i;

  always_comb begin
    w_cyc_g = 1'b0;
    case (r_state)
      GNT_I:   w_cyc_g = imem_cyc_i;
      GNT_D:   w_cyc_g = dmem_cyc_i;
      default: w_cyc_g = 1'b0;
    endcase
  end

  // A master that has already dropped cyc gets nothing, even a coincident ack.
  assign w_ack_g = w_cyc_g & wb_ack_i;

`ifdef FAZYRV_WB_ARB_TMO_EN
  logic w_expire;

  fazyrv_wb_tmo #(
    .TIMEOUT(TIMEOUT)
  ) u_tmo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .active_i(r_state != IDLE),
    .ack_i   (wb_ack_i),
    .expire_o(w_expire)
  );

  assign w_tmo = w_expire & w_cyc_g;
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_last_dmem <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_last_dmem <= w_last_dmem_next;
    end
  end

  always_comb begin
    w_next           = r_state;
    w_last_dmem_next = r_last_dmem;
    case (r_state)
      IDLE: begin
        if (w_req_i && w_req_d) begin
          w_next = (DMEM_PRIO || !r_last_dmem) ? GNT_D : GNT_I;
        end else if (w_req_d) begin
          w_next = GNT_D;
        end else if (w_req_i) begin
          w_next = GNT_I;
        end
        if (w_next == GNT_D) w_last_dmem_next = 1'b1;
        if (w_next == GNT_I) w_last_dmem_next = 1'b0;
      end
      // Every grant ends in IDLE, which gives the mandatory gap cycle.
      GNT_I, GNT_D: begin
        if (!w_cyc_g || w_ack_g || w_tmo) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    wb_cyc_o   = 1'b0;
    wb_stb_o   = 1'b0;
    wb_we_o    = 1'b0;
    wb_be_o    = 4'h0;
    wb_adr_o   = 32'h0;
    wb_dat_o   = 32'h0;
    imem_ack_o = 1'b0;
    dmem_ack_o = 1'b0;
    imem_dat_o = wb_dat_i;
    dmem_dat_o = wb_dat_i;
    case (r_state)
      GNT_I: begin
        wb_cyc_o   = w_req_i & ~w_tmo;
        wb_stb_o   = w_req_i & ~w_tmo;
        wb_be_o    = 4'hF;
        wb_adr_o   = imem_adr_i;
        imem_ack_o = w_ack_g | w_tmo;
        if (w_tmo) imem_dat_o = 32'h0;
      end
      GNT_D: begin
        wb_cyc_o   = w_req_d & ~w_tmo;
        wb_stb_o   = w_req_d & ~w_tmo;
        wb_we_o    = dmem_we_i;
        wb_be_o    = dmem_be_i;
        wb_adr_o   = dmem_adr_i;
        wb_dat_o   = dmem_dat_i;
        dmem_ack_o = w_ack_g | w_tmo;
        if (w_tmo) dmem_dat_o = 32'h0;
      end
      default: ;
    endcase
  end

  assign gnt_o = state_to_gnt(r_state);
  assign tmo_o = w_tmo;

endmodule

// File: tb/tb_fazyrv_wb_arb.sv
// tb/tb_fazyrv_wb_arb.sv - bench for fazyrv_wb_arb: RR and DMEM instances on shared stimulus
// Timeout scenarios run when FAZYRV_WB_ARB_TMO_EN is defined.
module tb_fazyrv_wb_arb;

`ifdef FAZYRV_WB_ARB_TMO_EN
  localparam bit TB_TMO = 1'b1;
`else
  localparam bit TB_TMO = 1'b0;
`endif
  localparam int TB_TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        imem_cyc, imem_stb, dmem_cyc, dmem_stb, dmem_we, wb_ack;
  logic [31:0] imem_adr, dmem_adr, dmem_dat, wb_dat;
  logic [3:0]  dmem_be;

  logic [31:0] imem_dat_w [2];
  logic [31:0] dmem_dat_w [2];
  logic [31:0] wb_adr_w   [2];
  logic [31:0] wb_wdat_w  [2];
  logic [3:0]  wb_be_w    [2];
  logic [1:0]  gnt_w      [2];
  logic        imem_ack_w [2];
  logic        dmem_ack_w [2];
  logic        wb_cyc_w   [2];
  logic        wb_stb_w   [2];
  logic        wb_we_w    [2];
  logic        tmo_w      [2];

  fazyrv_wb_arb #(.PRIO("RR"), .TIMEOUT(TB_TIMEOUT)) u_rr (
    .clk_i(clk), .rst_i(rst),
    .imem_stb_i(imem_stb), .imem_cyc_i(imem_cyc), .imem_adr_i(imem_adr),
    .imem_dat_o(imem_dat_w[0]), .imem_ack_o(imem_ack_w[0]),
    .dmem_cyc_i(dmem_cyc), .dmem_stb_i(dmem_stb), .dmem_we_i(dmem_we), .dmem_be_i(dmem_be),
    .dmem_adr_i(dmem_adr), .dmem_dat_i(dmem_dat),
    .dmem_dat_o(dmem_dat_w[0]), .dmem_ack_o(dmem_ack_w[0]),
    .wb_cyc_o(wb_cyc_w[0]), .wb_stb_o(wb_stb_w[0]), .wb_we_o(wb_we_w[0]), .wb_be_o(wb_be_w[0]),
    .wb_adr_o(wb_adr_w[0]), .wb_dat_o(wb_wdat_w[0]), .wb_dat_i(wb_dat), .wb_ack_i(wb_ack),
    .gnt_o(gnt_w[0]), .tmo_o(tmo_w[0])
  );

  fazyrv_wb_arb #(.PRIO("DMEM"), .TIMEOUT(TB_TIMEOUT)) u_dm (
    .clk_i(clk), .rst_i(rst),
    .imem_stb_i(imem_stb), .imem_cyc_i(imem_cyc), .imem_adr_i(imem_adr),
    .imem_dat_o(imem_dat_w[1]), .imem_ack_o(imem_ack_w[1]),
    .dmem_cyc_i(dmem_cyc), .dmem_stb_i(dmem_stb), .dmem_we_i(dmem_we), .dmem_be_i(dmem_be),
    .dmem_adr_i(dmem_adr), .dmem_dat_i(dmem_dat),
    .dmem_dat_o(dmem_dat_w[1]), .dmem_ack_o(dmem_ack_w[1]),
    .wb_cyc_o(wb_cyc_w[1]), .wb_stb_o(wb_stb_w[1]), .wb_we_o(wb_we_w[1]), .wb_be_o(wb_be_w[1]),
    .wb_adr_o(wb_adr_w[1]), .wb_dat_o(wb_wdat_w[1]), .wb_dat_i(wb_dat), .wb_ack_i(wb_ack),
    .gnt_o(gnt_w[1]), .tmo_o(tmo_w[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: owner 0 = nobody, 1 = imem, 2 = dmem; waited = ackless grant cycles so far.
  int owner [2], nxt_owner [2], waited [2], nxt_waited [2];
  bit last_d [2], nxt_last_d [2];

  logic [1:0]  s_gnt [2];
  logic [31:0] s_dat_i [2], s_dat_d [2], s_adr [2], s_wdat [2];
  logic [3:0]  s_be [2];
  logic        s_stb [2], s_ack_i [2], s_ack_d [2], s_we [2], s_tmo [2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      owner[m] = 0; waited[m] = 0; last_d[m] = 1'b0;
      nxt_owner[m] = 0; nxt_waited[m] = 0; nxt_last_d[m] = 1'b0;
    end
  endtask

  task automatic check_inst(input int m);
    int o;
    bit ireq, dreq, cyc_g, req_g, ack_g, tmo_x;
    logic [31:0] e_adr, e_wdat, e_dat_i, e_dat_d;
    logic [3:0]  e_be;
    logic        e_we;
    string nm;
    o    = owner[m];
    nm   = (m == 0) ? "rr" : "dm";
    ireq = imem_cyc && imem_stb;
    dreq = dmem_cyc && dmem_stb;
    cyc_g = (o == 1) ? imem_cyc : (o == 2) ? dmem_cyc : 1'b0;
    req_g = (o == 1) ? ireq : (o == 2) ? dreq : 1'b0;
    ack_g = cyc_g && wb_ack;
    tmo_x = TB_TMO && cyc_g && !wb_ack && (waited[m] + 1 == TB_TIMEOUT);
    e_adr  = (o == 1) ? imem_adr : (o == 2) ? dmem_adr : 32'h0;
    e_we   = (o == 2) ? dmem_we : 1'b0;
    e_be   = (o == 1) ? 4'hF : (o == 2) ? dmem_be : 4'h0;
    e_wdat = (o == 2) ? dmem_dat : 32'h0;
    e_dat_i = (o == 1 && tmo_x) ? 32'h0 : wb_dat;
    e_dat_d = (o == 2 && tmo_x) ? 32'h0 : wb_dat;

    s_gnt[m] = gnt_w[m];     s_stb[m] = wb_stb_w[m];   s_we[m] = wb_we_w[m];
    s_be[m] = wb_be_w[m];    s_adr[m] = wb_adr_w[m];   s_wdat[m] = wb_wdat_w[m];
    s_ack_i[m] = imem_ack_w[m]; s_ack_d[m] = dmem_ack_w[m];
    s_dat_i[m] = imem_dat_w[m]; s_dat_d[m] = dmem_dat_w[m]; s_tmo[m] = tmo_w[m];

    check({nm, ".gnt"},   gnt_w[m],      (o == 1) ? 2'b01 : (o == 2) ? 2'b10 : 2'b00);
    check({nm, ".cyc"},   wb_cyc_w[m],   req_g && !tmo_x);
    check({nm, ".stb"},   wb_stb_w[m],   req_g && !tmo_x);
    check({nm, ".we"},    wb_we_w[m],    e_we);
    check({nm, ".be"},    wb_be_w[m],    e_be);
    check({nm, ".adr"},   wb_adr_w[m],   e_adr);
    check({nm, ".wdat"},  wb_wdat_w[m],  e_wdat);
    check({nm, ".ack_i"}, imem_ack_w[m], (o == 1) && (ack_g || tmo_x));
    check({nm, ".ack_d"}, dmem_ack_w[m], (o == 2) && (ack_g || tmo_x));
    check({nm, ".dat_i"}, imem_dat_w[m], e_dat_i);
    check({nm, ".dat_d"}, dmem_dat_w[m], e_dat_d);
    check({nm, ".tmo"},   tmo_w[m],      tmo_x);

    nxt_last_d[m] = last_d[m];
    if (o == 0) begin
      nxt_waited[m] = 0;
      if (ireq && dreq) nxt_owner[m] = (m == 1 || !last_d[m]) ? 2 : 1;
      else if (dreq)    nxt_owner[m] = 2;
      else if (ireq)    nxt_owner[m] = 1;
      else              nxt_owner[m] = 0;
      if (nxt_owner[m] != 0) nxt_last_d[m] = (nxt_owner[m] == 2);
    end else if (!cyc_g || ack_g || tmo_x) begin
      nxt_owner[m] = 0; nxt_waited[m] = 0;
    end else begin
      nxt_owner[m] = o; nxt_waited[m] = waited[m] + 1;
    end
  endtask

  // One clock: check outputs mid-cycle, advance the model at the edge, return just after it.
  task automatic step();
    @(negedge clk);
    for (int m = 0; m < 2; m++) check_inst(m);
    @(posedge clk);
    if (rst) model_reset();
    else begin
      for (int m = 0; m < 2; m++) begin
        owner[m] = nxt_owner[m]; waited[m] = nxt_waited[m]; last_d[m] = nxt_last_d[m];
      end
    end
    #1;
  endtask

  task automatic quiet();
    imem_cyc = 0; imem_stb = 0; dmem_cyc = 0; dmem_stb = 0; wb_ack = 0;
  endtask

  int q_rr [$];
  int q_dm [$];

  initial begin
    imem_adr = 0; dmem_adr = 0; dmem_dat = 0; dmem_be = 0; dmem_we = 0; wb_dat = 0;
    quiet();
    model_reset();
    step();
    check("reset.gnt", s_gnt[0], 2'b00);
    check("reset.stb", s_stb[0], 1'b0);
    check("reset.tmo", s_tmo[0], 1'b0);
    step();
    rst = 0;
    step();

    // Single imem read, slave acks one cycle after stb.
    imem_cyc = 1; imem_stb = 1; imem_adr = 32'h100;
    step();
    step();
    check("rd.stb", s_stb[0], 1'b1);
    check("rd.adr", s_adr[0], 32'h100);
    wb_ack = 1; wb_dat = 32'h13;
    step();
    check("rd.ack_i", s_ack_i[0], 1'b1);
    check("rd.dat_i", s_dat_i[0], 32'h13);
    check("rd.ack_d", s_ack_d[0], 1'b0);
    quiet();
    step();
    check("rd.gap", s_gnt[0], 2'b00);

    // Both masters keep requesting; slave acks every granted cycle.
    imem_cyc = 1; imem_stb = 1; dmem_cyc = 1; dmem_stb = 1; wb_ack = 1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (s_gnt[0] != 2'b00) q_rr.push_back(int'(s_gnt[0]));
      if (s_gnt[1] != 2'b00) q_dm.push_back(int'(s_gnt[1]));
    end
    check("rr.count", q_rr.size() >= 4, 1'b1);
    check("dm.count", q_dm.size() >= 4, 1'b1);
    for (int k = 0; k < 4 && k < q_rr.size(); k++)
      check($sformatf("rr.seq%0d", k), q_rr[k], (k % 2 == 0) ? 2 : 1);
    for (int k = 0; k < 4 && k < q_dm.size(); k++)
      check($sformatf("dm.seq%0d", k), q_dm[k], 2);
    quiet();
    step();
    step();

    // dmem write, then an imem fetch.
    dmem_cyc = 1; dmem_stb = 1; dmem_we = 1; dmem_be = 4'b0011;
    dmem_adr = 32'h2000; dmem_dat = 32'hCAFE_F00D;
    step();
    step();
    check("wr.we", s_we[0], 1'b1);
    check("wr.be", s_be[0], 4'b0011);
    check("wr.dat", s_wdat[0], 32'hCAFE_F00D);
    check("wr.adr", s_adr[0], 32'h2000);
    wb_ack = 1;
    step();
    quiet();
    dmem_we = 0;
    step();
    imem_cyc = 1; imem_stb = 1; imem_adr = 32'h104;
    step();
    step();
    check("if.we", s_we[0], 1'b0);
    check("if.be", s_be[0], 4'hF);
    check("if.wdat", s_wdat[0], 32'h0);
    wb_ack = 1;
    step();
    quiet();
    step();

    // Asynchronous reset in the middle of a dmem grant with an ack pending.
    dmem_cyc = 1; dmem_stb = 1;
    step();
    wb_ack = 1;
    #2;
    rst = 1; dmem_cyc = 0; dmem_stb = 0;
    #1;
    for (int m = 0; m < 2; m++) begin
      check($sformatf("rst%0d.stb", m), wb_stb_w[m], 1'b0);
      check($sformatf("rst%0d.gnt", m), gnt_w[m], 2'b00);
      check($sformatf("rst%0d.ack_d", m), dmem_ack_w[m], 1'b0);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("rst.late_ack", s_ack_d[0], 1'b0);
    end
    quiet();
    step();

    // Granted imem abandons the cycle; the late slave ack must be dropped.
    imem_cyc = 1; imem_stb = 1;
    step();
    step();
    check("ab.gnt", s_gnt[0], 2'b01);
    imem_cyc = 0; imem_stb = 0;
    step();
    check("ab.ack_i", s_ack_i[0], 1'b0);
    wb_ack = 1;
    step();
    check("ab.idle", s_gnt[0], 2'b00);
    check("ab.late_ack", s_ack_i[0], 1'b0);
    quiet();
    step();

`ifdef FAZYRV_WB_ARB_TMO_EN
    // Slave never acks: abort on the 4th grant cycle with zero data.
    dmem_cyc = 1; dmem_stb = 1; wb_dat = 32'hA5A5_5A5A;
    step();
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("to.tmo%0d", k), s_tmo[0], k == 4);
      check($sformatf("to.ack%0d", k), s_ack_d[0], k == 4);
    end
    check("to.dat", s_dat_d[0], 32'h0);
    check("to.stb", s_stb[0], 1'b0);
    quiet();
    step();
    // Slave acks exactly on the expiry cycle: the real ack wins.
    dmem_cyc = 1; dmem_stb = 1;
    step();
    for (int k = 1; k <= 3; k++) step();
    wb_ack = 1; wb_dat = 32'h55;
    step();
    check("tw.tmo", s_tmo[0], 1'b0);
    check("tw.ack", s_ack_d[0], 1'b1);
    check("tw.dat", s_dat_d[0], 32'h55);
    quiet();
    step();
`else
    // Without the watchdog a grant waits for the slave indefinitely.
    dmem_cyc = 1; dmem_stb = 1;
    step();
    for (int k = 0; k < 20; k++) step();
    check("hold.gnt", s_gnt[0], 2'b10);
    check("hold.tmo", s_tmo[0], 1'b0);
    wb_ack = 1;
    step();
    check("hold.ack", s_ack_d[0], 1'b1);
    quiet();
    step();
`endif

    // Random traffic: masters hold requests until acked, sometimes abort; slave acks at random.
    for (int k = 0; k < 2000; k++) begin
      if (!imem_cyc) begin
        if ($urandom_range(1, 0) == 1) begin
          imem_cyc = 1; imem_adr = $urandom;
        end
      end else if (s_ack_i[0]) begin
        if ($urandom_range(1, 0) == 1) imem_cyc = 0;
        else imem_adr = $urandom;
      end else if ($urandom_range(15, 0) == 0) begin
        imem_cyc = 0;
      end
      imem_stb = imem_cyc && ($urandom_range(7, 0) != 0);

      if (!dmem_cyc) begin
        if ($urandom_range(1, 0) == 1) begin
          dmem_cyc = 1; dmem_adr = $urandom; dmem_dat = $urandom;
          dmem_we = $urandom_range(1, 0) == 1; dmem_be = 4'($urandom_range(15, 0));
        end
      end else if (s_ack_d[0]) begin
        if ($urandom_range(1, 0) == 1) dmem_cyc = 0;
        else begin
          dmem_adr = $urandom; dmem_dat = $urandom;
        end
      end else if ($urandom_range(15, 0) == 0) begin
        dmem_cyc = 0;
      end
      dmem_stb = dmem_cyc && ($urandom_range(7, 0) != 0);

      wb_ack = $urandom_range(2, 0) == 0;
      wb_dat = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
